if_fetch: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline; it is the producing end of the IF→ID interface.
- Owns the PC register and drives the synchronous instruction SRAM request.
- Produces the `{ce, pc}` bus that the decode stage registers.
- Consumes the branch bus `{br_e, br_addr}` and the stall vector from the stall controller.
- Holds a branch redirect that arrives while the stage is stalled, so the redirect is never lost.

---
 rtl/if_fetch_if.sv | 25 ++
 rtl/if_fetch.sv | 62 ++++++
 tb/tb_if_fetch.sv | 138 +++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// IF-stage bus bundle: branch/stall inputs, IF->ID bus and instruction SRAM request.
interface if_fetch_if #(
  parameter int unsigned STALL_WD = 6
);
  logic [STALL_WD-1:0] stall;
  logic [32:0]         br_bus;
  logic [32:0]         if_to_id_bus;
  logic                inst_sram_en;
  logic [3:0]          inst_sram_wen;
  logic [31:0]         inst_sram_addr;
  logic [31:0]         inst_sram_wdata;
  logic                pc_adel;

  modport master (
    input  stall, br_bus,
    output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
           inst_sram_wdata, pc_adel
  );

  modport slave (
    output stall, br_bus,
    input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
           inst_sram_wdata, pc_adel
  );
endinterface

// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage: PC register, SRAM request, branch redirect held across stalls.
// Optional misaligned-fetch detection is enabled by defining IF_ADEL_CHECK_EN.
module if_fetch #(
  parameter int unsigned STALL_WD = 6,
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
  input  logic       clk,
  input  logic       rst,
  if_fetch_if.master bus
);
  logic [31:0] r_pc;
  logic        r_ce;
  logic        r_br_pend;
  logic [31:0] r_br_pend_addr;

  logic        w_br_e;
  logic [31:0] w_br_addr;
  logic [31:0] w_next_pc;
  logic        w_adel;

  assign w_br_e    = bus.br_bus[32];
  assign w_br_addr = bus.br_bus[31:0];

  // Live branch beats a pending one; otherwise sequential fetch with natural wrap.
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (w_br_e)
      w_next_pc = w_br_addr;
    else if (r_br_pend)
      w_next_pc = r_br_pend_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= RESET_PC;
      r_ce           <= 1'b0;
      r_br_pend      <= 1'b0;
      r_br_pend_addr <= '0;
    end else if (!bus.stall[0]) begin
      r_pc      <= w_next_pc;
      r_ce      <= 1'b1;
      r_br_pend <= 1'b0;
    end else if (w_br_e) begin
      // Capture redirect while stalled; a later one overwrites it.
      r_br_pend      <= 1'b1;
      r_br_pend_addr <= w_br_addr;
    end
  end

`ifdef IF_ADEL_CHECK_EN
  assign w_adel = r_ce & (r_pc[1:0] != 2'b00);
`else
  assign w_adel = 1'b0;
`endif

  assign bus.pc_adel         = w_adel;
  assign bus.inst_sram_en    = r_ce & ~w_adel;
  assign bus.inst_sram_addr  = r_pc;
  assign bus.inst_sram_wen   = '0;
  assign bus.inst_sram_wdata = '0;
  assign bus.if_to_id_bus    = {r_ce, r_pc};
endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch.
module tb_if_fetch;
  localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  if_fetch_if #(.STALL_WD(6)) bus ();

  if_fetch #(.STALL_WD(6), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] pc);
    chk({tag, " addr"}, {1'b0, bus.inst_sram_addr}, {1'b0, pc});
    chk({tag, " en"}, {32'b0, bus.inst_sram_en}, 33'd1);
    chk({tag, " bus"}, bus.if_to_id_bus, {1'b1, pc});
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    rst        = 1'b1;
    bus.stall  = '0;
    bus.br_bus = '0;

    // Reset
    step(); step(); step();
    chk("rst bus", bus.if_to_id_bus, {1'b0, RESET_PC});
    chk("rst en", {32'b0, bus.inst_sram_en}, 33'd0);
    chk("rst adel", {32'b0, bus.pc_adel}, 33'd0);
    chk("wen", {29'b0, bus.inst_sram_wen}, 33'd0);
    chk("wdata", {1'b0, bus.inst_sram_wdata}, 33'd0);

    // Sequential fetch after release
    rst = 1'b0;
    step(); chk_pc("seq0", 32'hBFC0_0000);
    step(); chk_pc("seq1", 32'hBFC0_0004);
    step(); chk_pc("seq2", 32'hBFC0_0008);

    // Unstalled branch
    bus.br_bus = {1'b1, 32'hBFC0_0100};
    step(); chk_pc("br", 32'hBFC0_0100);
    bus.br_bus = '0;
    step(); chk_pc("br+4", 32'hBFC0_0104);

    // Only stall[0] stops the PC
    bus.stall = 6'b111110;
    step(); chk_pc("upper stall", 32'hBFC0_0108);

    // Branch under 3-cycle stall
    bus.stall  = 6'b000011;
    bus.br_bus = {1'b1, 32'hBFC0_0200};
    step(); chk_pc("stall0", 32'hBFC0_0108);
    bus.br_bus = '0;
    step(); chk_pc("stall1", 32'hBFC0_0108);
    step(); chk_pc("stall2", 32'hBFC0_0108);
    bus.stall = '0;
    step(); chk_pc("pend rel", 32'hBFC0_0200);
    step(); chk_pc("pend clr", 32'hBFC0_0204);

    // Last pending branch wins, then live branch overrides it on release
    bus.stall  = 6'b000001;
    bus.br_bus = {1'b1, 32'hBFC0_0180};
    step(); chk_pc("coll hold0", 32'hBFC0_0204);
    bus.br_bus = {1'b1, 32'hBFC0_0200};
    step(); chk_pc("coll hold1", 32'hBFC0_0204);
    bus.stall  = '0;
    bus.br_bus = {1'b1, 32'hBFC0_0300};
    step(); chk_pc("coll", 32'hBFC0_0300);
    bus.br_bus = '0;
    step(); chk_pc("coll+4", 32'hBFC0_0304);

    // Mid-operation reset drops a pending branch
    bus.stall  = 6'b000001;
    bus.br_bus = {1'b1, 32'hBFC0_0400};
    step(); chk_pc("pre rst", 32'hBFC0_0304);
    bus.br_bus = '0;
    rst        = 1'b1;
    step();
    chk("midrst bus", bus.if_to_id_bus, {1'b0, RESET_PC});
    chk("midrst en", {32'b0, bus.inst_sram_en}, 33'd0);
    rst       = 1'b0;
    bus.stall = '0;
    step(); chk_pc("post rst0", 32'hBFC0_0000);
    step(); chk_pc("post rst1", 32'hBFC0_0004);

    // 32-bit wrap
    bus.br_bus = {1'b1, 32'hFFFF_FFFC};
    step(); chk_pc("wrap pre", 32'hFFFF_FFFC);
    bus.br_bus = '0;
    step(); chk_pc("wrap", 32'h0000_0000);

    // Misaligned fetch
    bus.br_bus = {1'b1, 32'hBFC0_0102};
    step();
    chk("mis bus", bus.if_to_id_bus, {1'b1, 32'hBFC0_0102});
    chk("mis addr", {1'b0, bus.inst_sram_addr}, {1'b0, 32'hBFC0_0102});
`ifdef IF_ADEL_CHECK_EN
    chk("mis adel", {32'b0, bus.pc_adel}, 33'd1);
    chk("mis en", {32'b0, bus.inst_sram_en}, 33'd0);
`else
    chk("mis adel", {32'b0, bus.pc_adel}, 33'd0);
    chk("mis en", {32'b0, bus.inst_sram_en}, 33'd1);
`endif
    bus.br_bus = '0;
    step();
    chk("mis+4 bus", bus.if_to_id_bus, {1'b1, 32'hBFC0_0106});
`ifdef IF_ADEL_CHECK_EN
    chk("mis+4 adel", {32'b0, bus.pc_adel}, 33'd1);
`else
    chk("mis+4 adel", {32'b0, bus.pc_adel}, 33'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
